// File: rtl/subleq_ctrl_pkg.sv
// subleq_ctrl_pkg: shared word size, sequencer state encodings and halt-target test.
package subleq_ctrl_pkg;
    localparam int WORD_SIZE       = 16;
    localparam int HALT_TARGET_MSB = WORD_SIZE - 1;

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        FETCH_C = 3'd3,
        READ_A  = 3'd4,
        READ_B  = 3'd5,
        WRITE   = 3'd6,
        HALT    = 3'd7
    } state_e;

    function automatic logic halt_target(input logic [WORD_SIZE-1:0] c);
        return c[HALT_TARGET_MSB];
    endfunction
endpackage

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: SUBLEQ instruction sequencer driving the PC controls and memory handshake.
// Optional SUBLEQ_HALT_EN: taken branches to a target with MSB set halt the core.
module subleq_ctrl
    import subleq_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [WORD_SIZE-1:0] pc_in,
    output logic                 pc_branch,
    output logic                 pc_inc,
    output logic [WORD_SIZE-1:0] pc_addr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic                 halted
);
    state_e state_q, state_d;
    logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d, c_q, c_d, da_q, da_d, db_q, db_d;
    logic [WORD_SIZE-1:0] r;
    logic take, stop, fetch;

    always_comb begin
        r     = db_q - da_q;
        take  = (r == '0) | r[WORD_SIZE-1];
`ifdef SUBLEQ_HALT_EN
        stop   = take & halt_target(c_q);
        halted = state_q == HALT;
`else
        stop   = 1'b0;
        halted = 1'b0;
`endif
        fetch     = state_q inside {FETCH_A, FETCH_B, FETCH_C};
        mem_req   = fetch | (state_q inside {READ_A, READ_B, WRITE});
        mem_we    = state_q == WRITE;
        mem_addr  = fetch ? pc_in :
                    (state_q == READ_A) ? a_q :
                    (state_q inside {READ_B, WRITE}) ? b_q : '0;
        mem_wdata = mem_we ? r : '0;
        // PC controls only fire on the completing handshake cycle
        pc_inc    = fetch & mem_ready;
        pc_branch = mem_we & mem_ready & take & ~stop;
        pc_addr   = c_q;
        a_d  = (state_q == FETCH_A && mem_ready) ? mem_rdata : a_q;
        b_d  = (state_q == FETCH_B && mem_ready) ? mem_rdata : b_q;
        c_d  = (state_q == FETCH_C && mem_ready) ? mem_rdata : c_q;
        da_d = (state_q == READ_A && mem_ready) ? mem_rdata : da_q;
        db_d = (state_q == READ_B && mem_ready) ? mem_rdata : db_q;
        state_d = state_q;
        case (state_q)
            START:   state_d = FETCH_A;
            FETCH_A: if (mem_ready) state_d = FETCH_B;
            FETCH_B: if (mem_ready) state_d = FETCH_C;
            FETCH_C: if (mem_ready) state_d = READ_A;
            READ_A:  if (mem_ready) state_d = READ_B;
            READ_B:  if (mem_ready) state_d = WRITE;
            WRITE:   if (mem_ready) state_d = stop ? HALT : FETCH_A;
            HALT:    state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= START;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            da_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            da_q    <= da_d;
            db_q    <= db_d;
        end
    end
endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: scoreboarded bench with a behavioural PC and memory around subleq_ctrl.
// Expectations follow SUBLEQ_HALT_EN when it is defined for the build.
module tb_subleq_ctrl;
    import subleq_ctrl_pkg::*;
    localparam int W = WORD_SIZE;

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         areset_n = 1'b0;
    logic [W-1:0] pc;
    logic         pc_branch, pc_inc, mem_req, mem_we, mem_ready, halted;
    logic [W-1:0] pc_addr, mem_addr, mem_wdata, mem_rdata;
    logic [W-1:0] mem [16];
    logic [W-1:0] init_mem [16];
    int           wait_n = 0;
    int           cnt = 0;
    int           checks = 0;
    int           errors = 0;
    int           inc_cnt = 0;
    int           br_cnt = 0;
    wr_t          exp_q[$];
    wr_t          e;
    logic         prev_wait = 1'b0;
    logic         prev_we;
    logic [W-1:0] prev_addr;

    subleq_ctrl dut (
        .clk(clk), .areset_n(areset_n), .pc_in(pc),
        .pc_branch(pc_branch), .pc_inc(pc_inc), .pc_addr(pc_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && (cnt >= wait_n);
    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk or negedge areset_n)
        if (!areset_n) pc <= '0;
        else if (pc_branch) pc <= pc_addr;
        else if (pc_inc) pc <= pc + 1'b1;

    always @(posedge clk) begin
        cnt <= (!mem_req || mem_ready) ? 0 : cnt + 1;
        if (!areset_n) mem <= init_mem;
        else if (mem_req && mem_we && mem_ready) mem[mem_addr[3:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (!areset_n) begin
            inc_cnt   = 0;
            br_cnt    = 0;
            prev_wait = 1'b0;
        end else begin
            if (mem_req && mem_we && mem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        errors++;
                        $display("FAIL write_value: got addr=%h data=%h, required addr=%h data=%h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
            end
            if (pc_inc) inc_cnt++;
            if (pc_branch) br_cnt++;
            checks++;
            if (pc_inc && pc_branch) begin
                errors++;
                $display("FAIL pc_exclusive: got inc=1 branch=1, required not both");
            end
            if (prev_wait) begin
                checks++;
                if (mem_addr !== prev_addr || mem_we !== prev_we) begin
                    errors++;
                    $display("FAIL wait_stable: got addr=%h we=%b, required addr=%h we=%b",
                             mem_addr, mem_we, prev_addr, prev_we);
                end
            end
            if (mem_req && !mem_ready) begin
                checks++;
                if (pc_inc || pc_branch) begin
                    errors++;
                    $display("FAIL wait_pc_ctrl: got inc=%b branch=%b, required 0 0", pc_inc, pc_branch);
                end
            end
            prev_wait = mem_req && !mem_ready;
            prev_addr = mem_addr;
            prev_we   = mem_we;
        end
    end

    function automatic void set_mem(input logic [W-1:0] m0, m1, m2, m3, m4);
        for (int i = 0; i < 16; i++) init_mem[i] = '0;
        init_mem[0] = m0;
        init_mem[1] = m1;
        init_mem[2] = m2;
        init_mem[3] = m3;
        init_mem[4] = m4;
    endfunction

    task automatic do_reset(input int w);
        @(negedge clk);
        areset_n = 1'b0;
        wait_n   = w;
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input int n);
        areset_n = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_write(input logic [W-1:0] a, input logic [W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic test_reset;
        set_mem(3, 4, 6, 7, 5);
        do_reset(0);
        checks++;
        if ({mem_req, mem_we, pc_inc, pc_branch, halted, mem_addr, mem_wdata, pc_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b inc=%b br=%b halt=%b addr=%h wdata=%h pc_addr=%h, required all 0",
                     mem_req, mem_we, pc_inc, pc_branch, halted, mem_addr, mem_wdata, pc_addr);
        end
        areset_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL start_idle: got mem_req=%b, required 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL first_fetch: got req=%b we=%b addr=%h, required 1 0 0000", mem_req, mem_we, mem_addr);
        end
    endtask

    task automatic test_branch_taken;
        set_mem(3, 4, 6, 7, 5);
        do_reset(0);
        expect_write(4, 16'hFFFE);
        run(7);
        checks++;
        if (pc !== 16'd6 || br_cnt !== 1 || inc_cnt !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL branch_taken: got pc=%h br=%0d inc=%0d pending=%0d, required pc=0006 br=1 inc=3 pending=0",
                     pc, br_cnt, inc_cnt, exp_q.size());
        end
    endtask

    task automatic test_not_taken;
        set_mem(3, 4, 6, 2, 5);
        do_reset(0);
        expect_write(4, 16'h0003);
        run(7);
        checks++;
        if (pc !== 16'd3 || br_cnt !== 0 || inc_cnt !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL not_taken: got pc=%h br=%0d inc=%0d pending=%0d, required pc=0003 br=0 inc=3 pending=0",
                     pc, br_cnt, inc_cnt, exp_q.size());
        end
    endtask

    task automatic test_zero;
        set_mem(3, 4, 6, 9, 9);
        do_reset(0);
        expect_write(4, 16'h0000);
        run(7);
        checks++;
        if (pc !== 16'd6 || br_cnt !== 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_result: got pc=%h br=%0d pending=%0d, required pc=0006 br=1 pending=0",
                     pc, br_cnt, exp_q.size());
        end
        set_mem(4, 4, 9, 0, 5);
        do_reset(0);
        expect_write(4, 16'h0000);
        run(7);
        checks++;
        if (pc !== 16'd9 || br_cnt !== 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL a_equals_b: got pc=%h br=%0d pending=%0d, required pc=0009 br=1 pending=0",
                     pc, br_cnt, exp_q.size());
        end
    endtask

    task automatic test_wait_states;
        set_mem(3, 4, 6, 7, 5);
        do_reset(3);
        expect_write(4, 16'hFFFE);
        run(24);
        checks++;
        if (pc !== 16'd3 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL wait_early: got pc=%h pending=%0d, required pc=0003 pending=1", pc, exp_q.size());
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pc !== 16'd6 || br_cnt !== 1 || inc_cnt !== 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_done: got pc=%h br=%0d inc=%0d pending=%0d, required pc=0006 br=1 inc=3 pending=0",
                     pc, br_cnt, inc_cnt, exp_q.size());
        end
    endtask

    task automatic test_halt;
        set_mem(3, 4, 16'h8000, 7, 5);
        do_reset(0);
        expect_write(4, 16'hFFFE);
        run(7);
`ifdef SUBLEQ_HALT_EN
        checks++;
        if (pc !== 16'd3 || br_cnt !== 0 || halted !== 1'b1 || mem_req !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL halt_enter: got pc=%h br=%0d halted=%b req=%b pending=%0d, required pc=0003 br=0 halted=1 req=0 pending=0",
                     pc, br_cnt, halted, mem_req, exp_q.size());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (pc !== 16'd3 || halted !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: got pc=%h halted=%b req=%b, required pc=0003 halted=1 req=0", pc, halted, mem_req);
        end
`else
        checks++;
        if (pc !== 16'h8000 || br_cnt !== 1 || halted !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL high_target: got pc=%h br=%0d halted=%b pending=%0d, required pc=8000 br=1 halted=0 pending=0",
                     pc, br_cnt, halted, exp_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid_write;
        set_mem(3, 4, 6, 7, 5);
        do_reset(3);
        run(21);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_ready !== 1'b0 || mem_addr !== 16'd4) begin
            errors++;
            $display("FAIL in_write_wait: got req=%b we=%b ready=%b addr=%h, required 1 1 0 0004",
                     mem_req, mem_we, mem_ready, mem_addr);
        end
        #2 areset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem[4] !== 16'd5) begin
            errors++;
            $display("FAIL reset_abort: got req=%b we=%b mem4=%h, required 0 0 0005", mem_req, mem_we, mem[4]);
        end
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: got mem_req=%b, required 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL restart_fetch: got req=%b we=%b addr=%h, required 1 0 0000", mem_req, mem_we, mem_addr);
        end
    endtask

    initial begin
        test_reset;
        test_branch_taken;
        test_not_taken;
        test_zero;
        test_wait_states;
        test_halt;
        test_reset_mid_write;
        do_reset(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
